dso_uart_cmd_if: RTL and testbench
==================================

Name: dso_uart_cmd_if

Overview:
- DUT-side command/response framer between the byte-level UART (RX/TX cores) and the DSO_dig command processor.
- Assembles three received bytes (opcode first) into a 24-bit command with a ready/clear handshake.
- Queues response bytes (single ACK/NAK bytes or multi-byte channel dumps) in a small FIFO and drives the UART transmitter one byte at a time.

Parameters:
- RESP_DEPTH, 4, response FIFO depth in bytes (power of 2, ≥2).
- TIMEOUT_CYC, 20'd1_000_000, clocks allowed between bytes of one frame (used only with CMD_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_rdy  in  1  UART RX byte available; held until cleared.
- rx_data  in  8  UART RX byte.
- clr_rx_rdy  out  1  combinational; high in the cycle a byte is captured.
- cmd  out  24  assembled command {byte0, byte1, byte2}.
- cmd_rdy  out  1  command valid; held until clr_cmd_rdy.
- clr_cmd_rdy  in  1  command processor consumed cmd.
- resp  in  8  response byte to send.
- send_resp  in  1  push resp into FIFO.
- resp_full  out  1  FIFO full; a push while full is dropped.
- trmt  out  1  one-cycle start pulse to UART TX.
- tx_data  out  8  byte for UART TX; stable from trmt until tx_done.
- tx_done  in  1  UART TX finished current byte.
- frame_err  out  1  one-cycle pulse on inter-byte timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: cmd=0, cmd_rdy=0, trmt=0, tx_data=0, frame_err=0, resp_full=0. FIFO is emptied and both FSMs go to IDLE.
  - A reset mid-frame or mid-transmit aborts it. The byte in flight at the UART is not tracked.
- RX FSM states: WAIT_B0, WAIT_B1, WAIT_B2, CMD_HOLD.
  - WAIT_Bn with rx_rdy=1: capture rx_data into cmd[23-8n -: 8], assert clr_rx_rdy in that cycle, advance.
  - Capture in WAIT_B2 sets cmd_rdy=1 on the next edge and enters CMD_HOLD.
  - CMD_HOLD: cmd is frozen and no bytes are accepted; rx_rdy stays pending and clr_rx_rdy stays 0.
  - clr_cmd_rdy=1 in CMD_HOLD: cmd_rdy=0 next edge, go to WAIT_B0. A pending byte is accepted the following cycle at the earliest.
  - clr_cmd_rdy outside CMD_HOLD is ignored.
  - Only 3 bytes are ever consumed per frame; clr_rx_rdy pulses exactly once per byte.
- Response FIFO: RESP_DEPTH entries with log2(depth)+1-bit read/write pointers. Full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
  - A push while full is dropped, except that push and pop in the same cycle while full are both accepted.
  - A push into an empty FIFO becomes visible the next cycle; there is no same-cycle bypass.
  - resp_full is registered from the pointers.
- TX FSM states: TX_IDLE, TX_BUSY.
  - TX_IDLE with FIFO non-empty: pop, load tx_data, pulse trmt for one cycle, go to TX_BUSY.
  - TX_BUSY: on tx_done go to TX_IDLE. The next pop happens no earlier than the cycle after tx_done.
  - Latency: send_resp at cycle N into an idle, empty path gives trmt at cycle N+2.
- Bytes are transmitted in push order with no duplication or loss other than drops while full.
- RX and TX paths are fully independent; simultaneous events on both sides are legal.

Optional Feature:
- CMD_TIMEOUT_EN defined:
  - A 20-bit counter clears on every captured byte and counts while in WAIT_B1 or WAIT_B2.
  - When the counter reaches TIMEOUT_CYC-1: discard partial bytes, return to WAIT_B0, pulse frame_err for one cycle. cmd keeps its old value.
  - A byte capture in the same cycle as the timeout wins; no error is raised.
- CMD_TIMEOUT_EN undefined: no counter; frame_err is tied 0 and partial frames wait indefinitely.

Decomposition:
- Package dso_uart_pkg:
  - rx_state_t and tx_state_t enums.
  - CMD_W=24, BYTE_W=8.
  - ACK=8'hA5, NAK=8'hEE constants, shared with the command processor.
- One sub-module, dso_resp_fifo: the parameterised byte FIFO with push/pop, full/empty.

Test Plan:
- Bytes 0x03, 0x3F, 0x00 spaced 100 clk → three clr_rx_rdy pulses; cmd_rdy rises 1 cycle after the third capture; cmd=24'h033F00.
- cmd_rdy held (clr_cmd_rdy=0), present byte 0x05 → clr_rx_rdy stays 0 for 50 cycles. Pulse clr_cmd_rdy → 0x05 captured as byte0 within 2 cycles.
- send_resp with 0xA5 at cycle N, idle path → trmt at N+2 with tx_data=0xA5. tx_done after 40 cycles → TX_IDLE, no further trmt.
- tx_done withheld, push 0x10..0x15 on consecutive cycles (RESP_DEPTH=4):
  - 0x10 is popped; 0x11–0x14 fill the FIFO and resp_full=1; 0x15 is dropped.
  - After releasing tx_done per byte: transmit order is 0x10–0x14.
- CMD_TIMEOUT_EN, TIMEOUT_CYC=1000: send 0x09, then idle 1000 cycles → frame_err one pulse, cmd_rdy=0. Then 0x08, 0x12, 0x34 → cmd=24'h081234.
- Assert rst for 1 cycle after 2 bytes of a frame → outputs at reset values. Next 0x06, 0x41, 0x00 → cmd=24'h064100.

Source files
------------

// File: rtl/dso_uart_pkg.sv
// Shared types and constants for the DSO UART command/response framer.
// ACK/NAK are the response bytes the command processor sends back.
package dso_uart_pkg;

    localparam int CMD_W  = 24;
    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ACK = 8'hA5;
    localparam logic [BYTE_W-1:0] NAK = 8'hEE;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        CMD_HOLD
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/dso_resp_fifo.sv
// Byte FIFO for queued responses; extra pointer MSB tells full from empty.
// Full is registered; a push while full only lands if a pop frees a slot.
module dso_resp_fifo
    import dso_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_nxt;
    logic [AW:0]       rd_nxt;
    logic              do_push;
    logic              do_pop;
    logic [BYTE_W-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_nxt = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_nxt = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dso_uart_cmd_if.sv
// UART command framer (3 bytes -> 24-bit cmd) and response byte sender.
// Define CMD_TIMEOUT_EN to abort stalled partial frames with frame_err.
module dso_uart_cmd_if
    import dso_uart_pkg::*;
#(
    parameter int          RESP_DEPTH  = 4,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    output logic              resp_full,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              frame_err
);

    rx_state_t         rx_state;
    rx_state_t         rx_next;
    logic              capture;
    logic              timeout;
    logic [BYTE_W-1:0] byte0;
    logic [BYTE_W-1:0] byte1;

    always_comb begin
        rx_next = rx_state;
        capture = 1'b0;
        unique case (rx_state)
            WAIT_B0: begin
                if (rx_rdy) begin
                    capture = 1'b1;
                    rx_next = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (rx_rdy) begin
                    capture = 1'b1;
                    rx_next = WAIT_B2;
                end
            end
            WAIT_B2: begin
                if (rx_rdy) begin
                    capture = 1'b1;
                    rx_next = CMD_HOLD;
                end
            end
            CMD_HOLD: begin
                if (clr_cmd_rdy) begin
                    rx_next = WAIT_B0;
                end
            end
            default: rx_next = WAIT_B0;
        endcase
        if (timeout) begin
            rx_next = WAIT_B0;
        end
    end

    assign clr_rx_rdy = capture;
    assign cmd_rdy    = (rx_state == CMD_HOLD);

    // Partial bytes live in a shadow so cmd only changes on a full frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= WAIT_B0;
            byte0    <= '0;
            byte1    <= '0;
            cmd      <= '0;
        end else begin
            rx_state <= rx_next;
            if (capture) begin
                unique case (rx_state)
                    WAIT_B0: byte0 <= rx_data;
                    WAIT_B1: byte1 <= rx_data;
                    WAIT_B2: cmd   <= {byte0, byte1, rx_data};
                    default: ;
                endcase
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [19:0] tmo_cnt;
    logic        mid_frame;
    logic        frame_err_q;

    assign mid_frame = (rx_state == WAIT_B1) || (rx_state == WAIT_B2);
    assign timeout   = mid_frame && !capture &&
                       (tmo_cnt == TIMEOUT_CYC - 20'd1);
    assign frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= timeout;
            if (capture || timeout || !mid_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 20'd1;
            end
        end
    end
`else
    logic unused_tmo;

    assign timeout    = 1'b0;
    assign frame_err  = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic              pop;
    logic              trmt_next;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_dout;

    dso_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (send_resp),
        .din   (resp),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (resp_full),
        .empty (fifo_empty)
    );

    always_comb begin
        tx_next   = tx_state;
        pop       = 1'b0;
        trmt_next = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    trmt_next = 1'b1;
                    tx_next   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            trmt     <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_next;
            trmt     <= trmt_next;
            if (pop) begin
                tx_data <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_dso_uart_cmd_if.sv
// Self-checking bench for dso_uart_cmd_if: vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_dso_uart_cmd_if;
    import dso_uart_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_full;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        frame_err;

    dso_uart_cmd_if #(
        .RESP_DEPTH  (DEPTH),
        .TIMEOUT_CYC (20'd1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_full   (resp_full),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         clr_cnt = 0;
    int         trmt_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] tx_log [$];

    always @(negedge clk) begin
        if (clr_rx_rdy) clr_cnt++;
        if (frame_err) ferr_cnt++;
        if (trmt) begin
            trmt_cnt++;
            tx_log.push_back(tx_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART RX model: byte stays pending until the DUT clears it.
    task automatic send_byte(input logic [7:0] b, input int max_cyc,
                             output bit ok);
        rx_data = b;
        rx_rdy  = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_rdy = 1'b0;
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_cmd"}, 32'(cmd), 32'h0);
        chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'h0);
        chk({tag, "_trmt"}, 32'(trmt), 32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_resp_full"}, 32'(resp_full), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        resp      = b;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
    endtask

    task automatic wait_trmt(input int base, input string name);
        int n;
        n = 0;
        while (trmt_cnt == base && n < 20) begin
            idle(1);
            n++;
        end
        chk(name, 32'(trmt_cnt), 32'(base + 1));
    endtask

    task automatic rx_random(input int frames);
        logic [7:0] b [3];
        bit         ok;
        int         c0;
        c0 = clr_cnt;
        for (int f = 0; f < frames; f++) begin
            for (int j = 0; j < 3; j++) b[j] = 8'($urandom);
            for (int j = 0; j < 3; j++) begin
                idle(int'($urandom_range(0, 5)));
                send_byte(b[j], 8, ok);
                chk("rnd_rx_capture", 32'(ok), 32'h1);
            end
            @(negedge clk);
            chk("rnd_cmd_rdy", 32'(cmd_rdy), 32'h1);
            chk("rnd_cmd", 32'(cmd), 32'({b[0], b[1], b[2]}));
            @(posedge clk);
            #1;
            idle(int'($urandom_range(0, 6)));
            clear_cmd();
        end
        idle(2);
        chk("rnd_clr_pulses", 32'(clr_cnt - c0), 32'(3 * frames));
    endtask

    // Reference: occupancy queue plus a transmitter-busy flag.
    task automatic tx_random(input int cycles);
        logic [7:0] q [$];
        bit         busy;
        int         wait_c;
        bit         exp_trmt;
        logic [7:0] exp_byte;
        bit         push;
        bit         done;
        bit         pop_now;
        logic [7:0] d;
        int         i;
        busy     = 1'b0;
        wait_c   = 0;
        exp_trmt = 1'b0;
        exp_byte = 8'h00;
        i        = 0;
        while (i < cycles || q.size() > 0 || busy || exp_trmt) begin
            if (i > cycles + 300) begin
                chk("rnd_drain", 32'(q.size()), 32'h0);
                break;
            end
            push      = (i < cycles) && ($urandom_range(0, 1) == 1);
            d         = 8'($urandom);
            done      = busy && (wait_c == 0);
            resp      = d;
            send_resp = push;
            tx_done   = done;
            @(negedge clk);
            chk("rnd_trmt", 32'(trmt), 32'(exp_trmt));
            if (exp_trmt) chk("rnd_tx_data", 32'(tx_data), 32'(exp_byte));
            chk("rnd_resp_full", 32'(resp_full), 32'(q.size() == DEPTH));
            pop_now  = !busy && (q.size() > 0);
            exp_trmt = pop_now;
            if (pop_now) begin
                exp_byte = q.pop_front();
                busy     = 1'b1;
                wait_c   = int'($urandom_range(0, 4));
            end else if (busy) begin
                if (done) busy = 1'b0;
                else if (wait_c > 0) wait_c--;
            end
            if (push && q.size() < DEPTH) q.push_back(d);
            @(posedge clk);
            #1;
            i++;
        end
        send_resp = 1'b0;
        tx_done   = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          gap;
        logic [23:0] exp_cmd;
    } rx_vec_t;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rx_vec_t    vecs [4];
        bit         ok;
        int         c0;
        int         t0;
        int         f0;
        logic [7:0] exp_tx [5];

        vecs[0] = '{8'h03, 8'h3F, 8'h00, 100, 24'h033F00};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 0, 24'hFFFFFF};
        vecs[2] = '{8'h00, 8'h80, 8'h01, 3, 24'h008001};
        vecs[3] = '{8'hA5, 8'hEE, 8'h5A, 1, 24'hA5EE5A};

        rst = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        send_resp = 1'b0;
        tx_done = 1'b0;
        idle(3);
        rst = 1'b0;
        check_reset_vals("reset");

        for (int v = 0; v < 4; v++) begin
            c0 = clr_cnt;
            for (int j = 0; j < 3; j++) begin
                idle(vecs[v].gap);
                if (j == 2) begin
                    @(negedge clk);
                    chk("vec_rdy_early", 32'(cmd_rdy), 32'h0);
                    @(posedge clk);
                    #1;
                end
                send_byte(j == 0 ? vecs[v].b0 : (j == 1 ? vecs[v].b1 : vecs[v].b2), 5, ok);
                chk("vec_capture", 32'(ok), 32'h1);
            end
            @(negedge clk);
            chk("vec_cmd_rdy", 32'(cmd_rdy), 32'h1);
            chk("vec_cmd", 32'(cmd), 32'(vecs[v].exp_cmd));
            @(posedge clk);
            #1;
            chk("vec_clr_pulses", 32'(clr_cnt - c0), 32'h3);
            if (v < 3) clear_cmd();
        end

        // Command held: a pending byte must wait for clr_cmd_rdy.
        c0 = clr_cnt;
        rx_data = 8'h05;
        rx_rdy = 1'b1;
        idle(50);
        chk("hold_no_clr", 32'(clr_cnt - c0), 32'h0);
        chk("hold_cmd", 32'(cmd), 32'hA5EE5A);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        chk("hold_clr_same_cyc", 32'(clr_rx_rdy), 32'h0);
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("hold_accept", 32'(clr_rx_rdy), 32'h1);
        chk("hold_rdy_drop", 32'(cmd_rdy), 32'h0);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        send_byte(8'h77, 5, ok);
        send_byte(8'h88, 5, ok);
        @(negedge clk);
        chk("hold_cmd_new", 32'(cmd), 32'h057788);
        @(posedge clk);
        #1;
        clear_cmd();

        // Single ACK: trmt two cycles after send_resp.
        tx_log.delete();
        t0 = trmt_cnt;
        resp = ACK;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        @(negedge clk);
        chk("ack_trmt_n1", 32'(trmt), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ack_trmt_n2", 32'(trmt), 32'h1);
        chk("ack_tx_data", 32'(tx_data), 32'hA5);
        @(posedge clk);
        #1;
        idle(40);
        tx_done = 1'b1;
        idle(1);
        tx_done = 1'b0;
        idle(10);
        chk("ack_one_trmt", 32'(trmt_cnt - t0), 32'h1);

        // Overflow: 0x10 leaves, 0x11-0x14 fill, 0x15 dropped.
        tx_log.delete();
        t0 = trmt_cnt;
        for (int k = 0; k < 6; k++) begin
            resp = 8'(8'h10 + k);
            send_resp = 1'b1;
            @(negedge clk);
            if (k == 4) chk("ovf_not_full", 32'(resp_full), 32'h0);
            if (k == 5) chk("ovf_full", 32'(resp_full), 32'h1);
            @(posedge clk);
            #1;
        end
        send_resp = 1'b0;
        idle(3);
        chk("ovf_first_trmt", 32'(trmt_cnt - t0), 32'h1);
        chk("ovf_still_full", 32'(resp_full), 32'h1);
        for (int k = 1; k < 5; k++) begin
            idle(2);
            tx_done = 1'b1;
            idle(1);
            tx_done = 1'b0;
            wait_trmt(t0 + k, "ovf_next_trmt");
        end
        idle(3);
        tx_done = 1'b1;
        idle(1);
        tx_done = 1'b0;
        idle(20);
        exp_tx = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk("ovf_count", 32'(tx_log.size()), 32'h5);
        for (int k = 0; k < 5 && k < tx_log.size(); k++)
            chk("ovf_order", 32'(tx_log[k]), 32'(exp_tx[k]));
        chk("ovf_empty_full", 32'(resp_full), 32'h0);

        // Stalled partial frame.
        f0 = ferr_cnt;
        send_byte(8'h09, 5, ok);
        idle(1100);
`ifdef CMD_TIMEOUT_EN
        chk("tmo_frame_err", 32'(ferr_cnt - f0), 32'h1);
        chk("tmo_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("tmo_cmd_kept", 32'(cmd), 32'h057788);
        send_byte(8'h08, 5, ok);
        send_byte(8'h12, 5, ok);
        send_byte(8'h34, 5, ok);
        @(negedge clk);
        chk("tmo_cmd_rdy_new", 32'(cmd_rdy), 32'h1);
        chk("tmo_cmd_new", 32'(cmd), 32'h081234);
`else
        chk("nto_frame_err", 32'(ferr_cnt - f0), 32'h0);
        chk("nto_cmd_rdy", 32'(cmd_rdy), 32'h0);
        send_byte(8'hAA, 5, ok);
        send_byte(8'hBB, 5, ok);
        @(negedge clk);
        chk("nto_cmd_rdy_new", 32'(cmd_rdy), 32'h1);
        chk("nto_cmd_new", 32'(cmd), 32'h09AABB);
`endif
        @(posedge clk);
        #1;
        clear_cmd();

        // Reset mid-frame and mid-transmit with a full FIFO.
        for (int k = 0; k < 5; k++) push_byte(8'(8'h20 + k));
        idle(2);
        send_byte(8'h61, 5, ok);
        send_byte(8'h62, 5, ok);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_vals("midrst");
        t0 = trmt_cnt;
        idle(5);
        chk("midrst_no_trmt", 32'(trmt_cnt - t0), 32'h0);
        send_byte(8'h06, 5, ok);
        send_byte(8'h41, 5, ok);
        send_byte(8'h00, 5, ok);
        @(negedge clk);
        chk("midrst_cmd", 32'(cmd), 32'h064100);
        @(posedge clk);
        #1;
        clear_cmd();
        idle(2);

        fork
            rx_random(25);
            tx_random(400);
        join

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
